// File: rtl/fir_mac_mc.sv
// fir_mac_mc: multi-channel, time-multiplexed FIR filter with one shared MAC.
module fir_mac_mc #(
  parameter int DATA_W   = 16,
  parameter int COEFF_W  = 16,
  parameter int TAPS     = 7,
  parameter int CHANNELS = 2,
  parameter int GUARD    = 6,
  localparam int OUT_W   = DATA_W + COEFF_W + GUARD,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TA_W    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CH_W-1:0]    in_ch,
  input  logic               coef_we,
  input  logic [TA_W-1:0]    coef_addr,
  input  logic [COEFF_W-1:0] coef_data,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic [CH_W-1:0]    out_ch
);

  localparam int PROD_W = DATA_W + COEFF_W;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   x_q [CHANNELS][TAPS];
  logic signed [DATA_W-1:0]   x_d [CHANNELS][TAPS];
  logic signed [COEFF_W-1:0]  h_q [TAPS];
  logic signed [COEFF_W-1:0]  h_d [TAPS];
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [TA_W-1:0]            k_q, k_d;
  logic [OUT_W-1:0]           acc_q, acc_d;
  logic                       out_valid_q, out_valid_d;
  logic [OUT_W-1:0]           out_data_q, out_data_d;
  logic [CH_W-1:0]            out_ch_q, out_ch_d;
  logic signed [PROD_W-1:0]   prod;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    h_d         = h_q;
    ch_d        = ch_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    prod        = x_q[ch_q][k_q] * h_q[k_q];

    case (state_q)
      IDLE: begin
        // Coefficient write lands on the same edge as an acceptance, so the
        // pass that follows already sees the new value.
        if (coef_we && (int'(coef_addr) < TAPS)) begin
          h_d[coef_addr] = coef_data;
        end
        if (in_valid && (int'(in_ch) < CHANNELS)) begin
          for (int unsigned k = 1; k < TAPS; k++) begin
            x_d[in_ch][k] = x_q[in_ch][k-1];
          end
          x_d[in_ch][0] = in_data;
          ch_d          = in_ch;
          k_d           = '0;
          acc_d         = '0;
          state_d       = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{GUARD{prod[PROD_W-1]}}, prod};
        k_d   = k_q + TA_W'(1);
        if (k_q == TA_W'(TAPS - 1)) begin
          out_data_d  = acc_d;
          out_ch_d    = ch_q;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '{default: '0};
      h_q         <= '{default: '0};
      ch_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      h_q         <= h_d;
      ch_q        <= ch_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

endmodule
